// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter in front of the 1W/2R register file: ALU has priority, LSU results
// are buffered in a small FIFO, and a starvation timer forces a FIFO pop when it waits too long.
//
//   state  | meaning
//   IDLE   | FIFO empty, starve counter parked at 0
//   WAIT   | FIFO holds data; counting cycles in which the head was not popped
//   FORCE  | starvation bound hit; ALU blocked this cycle so the head drains
module rf_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1,
  localparam int SW = $clog2(STARVE_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_vld,
  output logic          alu_rdy,
  input  logic [4:0]    alu_rd,
  input  logic [31:0]   alu_data,
  input  logic          lsu_vld,
  output logic          lsu_rdy,
  input  logic [4:0]    lsu_rd,
  input  logic [31:0]   lsu_data,
  output logic          en4w,
  output logic [4:0]    addr_w0,
  output logic [31:0]   data_i0,
  input  logic [4:0]    rf_addr0,
  input  logic [31:0]   rf_q0,
  output logic [31:0]   fwd_q0,
  input  logic [4:0]    rf_addr1,
  input  logic [31:0]   rf_q1,
  output logic [31:0]   fwd_q1,
  output logic [CW-1:0] fifo_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FORCE} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] ctr_q, ctr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic          en4w_q, en4w_d;
  logic [4:0]    addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [4:0]    mem_rd_q   [DEPTH];
  logic [31:0]   mem_data_q [DEPTH];

  logic        alu_take, lsu_take, fifo_ne, push, pop;
  logic        slot_vld;
  logic [4:0]  slot_rd;
  logic [31:0] slot_data;

  // Ready terms are gated by rst_n so nothing is accepted while reset is asserted.
  assign alu_rdy  = rst_n && (state_q != S_FORCE);
  assign lsu_rdy  = rst_n && (cnt_q < CW'(DEPTH));
  assign alu_take = alu_vld && alu_rdy;
  assign lsu_take = lsu_vld && lsu_rdy;
  assign fifo_ne  = (cnt_q != '0);
  assign pop      = !alu_take && fifo_ne;
  assign push     = lsu_take && (alu_take || fifo_ne);

  always_comb begin
    slot_vld  = 1'b0;
    slot_rd   = 5'd0;
    slot_data = 32'd0;
    if (alu_take) begin
      slot_vld  = 1'b1;
      slot_rd   = alu_rd;
      slot_data = alu_data;
    end else if (fifo_ne) begin
      slot_vld  = 1'b1;
      slot_rd   = mem_rd_q[rd_ptr_q];
      slot_data = mem_data_q[rd_ptr_q];
    end else if (lsu_take) begin
      slot_vld  = 1'b1;
      slot_rd   = lsu_rd;
      slot_data = lsu_data;
    end
    // x0 slots are consumed but never written; address/data hold their last value.
    en4w_d = slot_vld && (slot_rd != 5'd0);
    addr_d = en4w_d ? slot_rd : addr_q;
    data_d = en4w_d ? slot_data : data_q;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + (pop  ? AW'(1) : AW'(0));
    wr_ptr_d = wr_ptr_q + (push ? AW'(1) : AW'(0));
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    case (state_q)
      S_IDLE: begin
        ctr_d = '0;
        if (cnt_d != '0) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_d == '0) begin
          state_d = S_IDLE;
          ctr_d   = '0;
        end else if (pop) begin
          ctr_d = '0;
        end else begin
          ctr_d = ctr_q + SW'(1);
          if (ctr_d == SW'(STARVE_MAX)) state_d = S_FORCE;
        end
      end
      S_FORCE: begin
        ctr_d   = '0;
        state_d = (cnt_d != '0) ? S_WAIT : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        ctr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ctr_q    <= '0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      en4w_q   <= 1'b0;
      addr_q   <= 5'd0;
      data_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      en4w_q   <= en4w_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd_q[wr_ptr_q]   <= lsu_rd;
      mem_data_q[wr_ptr_q] <= lsu_data;
    end
  end

  assign en4w     = en4w_q;
  assign addr_w0  = addr_q;
  assign data_i0  = data_q;
  assign fifo_cnt = cnt_q;

  assign fwd_q0 = (en4w_q && (addr_q == rf_addr0) && (rf_addr0 != 5'd0)) ? data_q : rf_q0;
  assign fwd_q1 = (en4w_q && (addr_q == rf_addr1) && (rf_addr1 != 5'd0)) ? data_q : rf_q1;

endmodule
